// File: rtl/descriptor_ram_dp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : descriptor_ram_pkg
// Purpose  : Shared types, constants and helpers for the dual-port
//            descriptor RAM.
// Revision : 1.0 - initial release
// ============================================================================
package descriptor_ram_pkg;

  // Maximum supported read latency (1 = unregistered q, 2 = registered q)
  localparam int READ_LATENCY_MAX = 2;

  // Controller state: zero-fill sweep or normal operation
  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  // Ceiling log2 usable in constant expressions
  function automatic int clog2_f(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/descriptor_ram_dp_if.sv
`default_nettype none
// ============================================================================
// Module   : descriptor_ram_dp_if
// Purpose  : Avalon-MM slave port bundle for one descriptor RAM port.
// Revision : 1.0 - initial release
// ============================================================================
interface descriptor_ram_dp_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
);

  logic [ADDR_WIDTH-1:0]   address;
  logic                    chipselect;
  logic                    read;
  logic                    write;
  logic [DATA_WIDTH/8-1:0] byteenable;
  logic [DATA_WIDTH-1:0]   writedata;
  logic [DATA_WIDTH-1:0]   readdata;
  logic                    readdatavalid;
  logic                    waitrequest;

  modport master (
    output address, chipselect, read, write, byteenable, writedata,
    input  readdata, readdatavalid, waitrequest
  );

  modport slave (
    input  address, chipselect, read, write, byteenable, writedata,
    output readdata, readdatavalid, waitrequest
  );

endinterface
`default_nettype wire

// File: rtl/descriptor_ram_dp_core.sv
`default_nettype none
// ============================================================================
// Module   : dpram_core
// Purpose  : True dual-port byte-enabled RAM, registered q, old data on
//            read-during-write (both same-port and cross-port).
// Revision : 1.0 - initial release
// ============================================================================
module dpram_core #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                    clk,
  input  logic                    en,
  input  logic                    we_a,
  input  logic [ADDR_WIDTH-1:0]   addr_a,
  input  logic [DATA_WIDTH/8-1:0] be_a,
  input  logic [DATA_WIDTH-1:0]   wd_a,
  output logic [DATA_WIDTH-1:0]   q_a,
  input  logic                    we_b,
  input  logic [ADDR_WIDTH-1:0]   addr_b,
  input  logic [DATA_WIDTH/8-1:0] be_b,
  input  logic [DATA_WIDTH-1:0]   wd_b,
  output logic [DATA_WIDTH-1:0]   q_b
);

  localparam int NUM_BYTES = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Both ports read the pre-edge contents and commit enabled byte lanes.
  // The top level guarantees the two ports never write one address together.
  always_ff @(posedge clk) begin
    if (en) begin
      q_a <= mem[addr_a];
      q_b <= mem[addr_b];
      for (int b = 0; b < NUM_BYTES; b++) begin
        if (we_a && be_a[b]) begin
          mem[addr_a][b*8 +: 8] <= wd_a[b*8 +: 8];
        end
        if (we_b && be_b[b]) begin
          mem[addr_b][b*8 +: 8] <= wd_b[b*8 +: 8];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/descriptor_ram_dp.sv
`default_nettype none
// ============================================================================
// Module   : descriptor_ram_dp
// Purpose  : Dual-port Avalon-MM descriptor memory with clear-on-reset
//            sweep, write-collision arbitration and readdatavalid pipelines.
// Revision : 1.0 - initial release
// ============================================================================
module descriptor_ram_dp
  import descriptor_ram_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int DEPTH          = 1024,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic reset_req,
  input  logic clken,
  descriptor_ram_dp_if.slave s1,
  descriptor_ram_dp_if.slave s2,
  output logic init_busy
);

  localparam int ADDR_WIDTH = clog2_f(DEPTH);
  localparam int NUM_BYTES  = DATA_WIDTH / 8;
  localparam int LATENCY    = (READ_LATENCY >= READ_LATENCY_MAX) ? READ_LATENCY_MAX : 1;

  logic                  en;
  state_t                state;
  logic [ADDR_WIDTH-1:0] cnt;

  // Port 0 is s1, port 1 is s2
  logic [ADDR_WIDTH-1:0] addr [2];
  logic [NUM_BYTES-1:0]  be   [2];
  logic [DATA_WIDTH-1:0] wd   [2];
  logic [DATA_WIDTH-1:0] q    [2];
  logic [DATA_WIDTH-1:0] rdata[2];
  logic [1:0]            cs, rd, wr;
  logic [1:0]            req, stall, acc, wr_acc, rd_acc, rvalid;
  logic                  active, collide;

  logic                  ram_we_a;
  logic [ADDR_WIDTH-1:0] ram_addr_a;
  logic [NUM_BYTES-1:0]  ram_be_a;
  logic [DATA_WIDTH-1:0] ram_wd_a;

  assign en = clken & ~reset_req;

  assign addr[0] = s1.address;    assign addr[1] = s2.address;
  assign be[0]   = s1.byteenable; assign be[1]   = s2.byteenable;
  assign wd[0]   = s1.writedata;  assign wd[1]   = s2.writedata;
  assign cs      = {s2.chipselect, s1.chipselect};
  assign rd      = {s2.read, s1.read};
  assign wr      = {s2.write, s1.write};

  // Same-address write from both ports: s1 wins, s2 retries next cycle
  assign active   = (state == READY) & ~reset & en;
  assign collide  = cs[0] & wr[0] & cs[1] & wr[1] & (addr[0] == addr[1]);
  assign stall[0] = ~active;
  assign stall[1] = ~active | collide;
  assign req      = cs & (rd | wr);
  assign acc      = req & ~stall;
  assign wr_acc   = acc & wr;
  assign rd_acc   = acc & rd & ~wr;

  assign init_busy = (state == CLEAR);

  // Sweep controller: zero-fills one word per enabled cycle, then READY
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      if (CLEAR_ON_RESET != 0) begin
        state <= CLEAR;
      end else begin
        state <= READY;
      end
    end else if (state == CLEAR && en) begin
      cnt <= cnt + 1'b1;
      if (cnt == ADDR_WIDTH'(DEPTH - 1)) begin
        state <= READY;
      end
    end
  end

  // Port A is borrowed by the sweep while clearing, otherwise serves s1
  always_comb begin
    if (state == CLEAR) begin
      ram_we_a   = ~reset;
      ram_addr_a = cnt;
      ram_be_a   = '1;
      ram_wd_a   = '0;
    end else begin
      ram_we_a   = wr_acc[0];
      ram_addr_a = addr[0];
      ram_be_a   = be[0];
      ram_wd_a   = wd[0];
    end
  end

  dpram_core #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_core (
    .clk    (clk),
    .en     (en),
    .we_a   (ram_we_a),
    .addr_a (ram_addr_a),
    .be_a   (ram_be_a),
    .wd_a   (ram_wd_a),
    .q_a    (q[0]),
    .we_b   (wr_acc[1]),
    .addr_b (addr[1]),
    .be_b   (be[1]),
    .wd_b   (wd[1]),
    .q_b    (q[1])
  );

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic                  v0;
    logic                  pre_v;
    logic [DATA_WIDTH-1:0] pre_d;
    logic                  rvalid_r;
    logic [DATA_WIDTH-1:0] rdata_r;

    // Valid bit aligned with the RAM's registered q; stalls with en
    always_ff @(posedge clk) begin
      if (reset) begin
        v0 <= 1'b0;
      end else if (en) begin
        v0 <= rd_acc[p];
      end
    end

    if (LATENCY == 2) begin : g_q_reg
      logic                  v1;
      logic [DATA_WIDTH-1:0] d1;

      // Extra q register stage for the two-cycle configuration
      always_ff @(posedge clk) begin
        if (reset) begin
          v1 <= 1'b0;
        end else if (en) begin
          v1 <= v0;
          d1 <= q[p];
        end
      end

      assign pre_v = v1;
      assign pre_d = d1;
    end else begin : g_q_direct
      assign pre_v = v0;
      assign pre_d = q[p];
    end

    // Output register: readdata only moves when a valid word arrives
    always_ff @(posedge clk) begin
      if (reset) begin
        rvalid_r <= 1'b0;
        rdata_r  <= '0;
      end else if (en) begin
        rvalid_r <= pre_v;
        if (pre_v) begin
          rdata_r <= pre_d;
        end
      end
    end

    assign rvalid[p] = rvalid_r;
    assign rdata[p]  = rdata_r;
  end

  assign s1.readdata      = rdata[0];
  assign s1.readdatavalid = rvalid[0];
  assign s1.waitrequest   = stall[0];
  assign s2.readdata      = rdata[1];
  assign s2.readdatavalid = rvalid[1];
  assign s2.waitrequest   = stall[1];

endmodule
`default_nettype wire

// File: tb/tb_descriptor_ram_dp.sv
`default_nettype none
// ============================================================================
// Module   : tb_descriptor_ram_dp
// Purpose  : Self-checking bench for descriptor_ram_dp (latency 1 and 2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_descriptor_ram_dp;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset, reset_req, clken;
  logic init_busy1, init_busy2;
  int   checks, errors;
  int   cyc = 0;

  exp_t q0[$], q1[$], q2[$];
  exp_t e0, e1, e2;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  descriptor_ram_dp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) a1();
  descriptor_ram_dp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) b1();
  descriptor_ram_dp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) a2();
  descriptor_ram_dp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) b2();

  descriptor_ram_dp #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .READ_LATENCY(1), .CLEAR_ON_RESET(1)) dut_l1 (
    .clk(clk), .reset(reset), .reset_req(reset_req), .clken(clken),
    .s1(a1), .s2(b1), .init_busy(init_busy1));

  descriptor_ram_dp #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .READ_LATENCY(2), .CLEAR_ON_RESET(1)) dut_l2 (
    .clk(clk), .reset(reset), .reset_req(reset_req), .clken(clken),
    .s1(a2), .s2(b2), .init_busy(init_busy2));

  // Scoreboard monitors: pop expected word and arrival cycle on each valid
  always @(negedge clk) begin
    if (a1.readdatavalid === 1'b1) begin
      checks++;
      if (q0.size() == 0) begin
        errors++;
        $display("FAIL p0_unexpected_valid cyc=%0d data=%h", cyc, a1.readdata);
      end else begin
        e0 = q0.pop_front();
        if (a1.readdata !== e0.data || cyc != e0.cyc) begin
          errors++;
          $display("FAIL p0_read got data=%h cyc=%0d expected data=%h cyc=%0d", a1.readdata, cyc, e0.data, e0.cyc);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (b1.readdatavalid === 1'b1) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL p1_unexpected_valid cyc=%0d data=%h", cyc, b1.readdata);
      end else begin
        e1 = q1.pop_front();
        if (b1.readdata !== e1.data || cyc != e1.cyc) begin
          errors++;
          $display("FAIL p1_read got data=%h cyc=%0d expected data=%h cyc=%0d", b1.readdata, cyc, e1.data, e1.cyc);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (a2.readdatavalid === 1'b1) begin
      checks++;
      if (q2.size() == 0) begin
        errors++;
        $display("FAIL p2_unexpected_valid cyc=%0d data=%h", cyc, a2.readdata);
      end else begin
        e2 = q2.pop_front();
        if (a2.readdata !== e2.data || cyc != e2.cyc) begin
          errors++;
          $display("FAIL p2_read got data=%h cyc=%0d expected data=%h cyc=%0d", a2.readdata, cyc, e2.data, e2.cyc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  // Port 0 = latency-1 s1, 1 = latency-1 s2, 2 = latency-2 s1
  task automatic drive(input int p, input logic cs, input logic rd, input logic wr,
                       input logic [AW-1:0] ad, input logic [3:0] be, input logic [DW-1:0] wd);
    case (p)
      0: begin a1.chipselect = cs; a1.read = rd; a1.write = wr; a1.address = ad; a1.byteenable = be; a1.writedata = wd; end
      1: begin b1.chipselect = cs; b1.read = rd; b1.write = wr; b1.address = ad; b1.byteenable = be; b1.writedata = wd; end
      default: begin a2.chipselect = cs; a2.read = rd; a2.write = wr; a2.address = ad; a2.byteenable = be; a2.writedata = wd; end
    endcase
  endtask

  function automatic logic wait_of(input int p);
    case (p)
      0:       return a1.waitrequest;
      1:       return b1.waitrequest;
      default: return a2.waitrequest;
    endcase
  endfunction

  function automatic void push_exp(input int p, input logic [DW-1:0] d, input int c);
    exp_t e;
    e.data = d;
    e.cyc  = c;
    case (p)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endfunction

  // Called just after a rising edge; returns just after the accepting edge
  task automatic issue_write(input int p, input logic [AW-1:0] ad, input logic [DW-1:0] wd, input logic [3:0] be);
    int guard;
    drive(p, 1'b1, 1'b0, 1'b1, ad, be, wd);
    @(negedge clk);
    guard = 0;
    while (wait_of(p) !== 1'b0 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (guard >= 40) begin
      errors++;
      $display("FAIL write_accept p=%0d waitrequest=%b expected 0 within 40 cycles", p, wait_of(p));
    end
    @(posedge clk);
    #1;
    drive(p, 1'b0, 1'b0, 1'b0, '0, 4'h0, '0);
  endtask

  task automatic issue_read(input int p, input logic [AW-1:0] ad, input logic [DW-1:0] exp_d, input int extra);
    int guard;
    int lat;
    lat = (p == 2) ? 2 : 1;
    drive(p, 1'b1, 1'b1, 1'b0, ad, 4'hF, '0);
    @(negedge clk);
    guard = 0;
    while (wait_of(p) !== 1'b0 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (guard >= 40) begin
      errors++;
      $display("FAIL read_accept p=%0d waitrequest=%b expected 0 within 40 cycles", p, wait_of(p));
    end
    push_exp(p, exp_d, cyc + 1 + lat + extra);
    @(posedge clk);
    #1;
    drive(p, 1'b0, 1'b0, 1'b0, '0, 4'h0, '0);
  endtask

  task automatic test_reset();
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (a1.readdata !== 32'h0 || a1.readdatavalid !== 1'b0 || b1.readdatavalid !== 1'b0 || a2.readdatavalid !== 1'b0) begin
      errors++;
      $display("FAIL reset_read got data=%h valid=%b%b%b expected 0 and 000", a1.readdata, a1.readdatavalid, b1.readdatavalid, a2.readdatavalid);
    end
    checks++;
    if (a1.waitrequest !== 1'b1 || b1.waitrequest !== 1'b1 || a2.waitrequest !== 1'b1) begin
      errors++;
      $display("FAIL reset_wait got %b%b%b expected 111", a1.waitrequest, b1.waitrequest, a2.waitrequest);
    end
    checks++;
    if (init_busy1 !== 1'b1 || init_busy2 !== 1'b1) begin
      errors++;
      $display("FAIL reset_init_busy got %b%b expected 11", init_busy1, init_busy2);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_clear_sweep();
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      checks++;
      if (init_busy1 !== 1'b1 || init_busy2 !== 1'b1 || a1.waitrequest !== 1'b1 || b1.waitrequest !== 1'b1) begin
        errors++;
        $display("FAIL sweep_busy cycle=%0d got busy=%b%b wait=%b%b expected 11 11", i, init_busy1, init_busy2, a1.waitrequest, b1.waitrequest);
      end
    end
    @(negedge clk);
    checks++;
    if (init_busy1 !== 1'b0 || init_busy2 !== 1'b0 || a1.waitrequest !== 1'b0 || b1.waitrequest !== 1'b0 || a2.waitrequest !== 1'b0) begin
      errors++;
      $display("FAIL sweep_done got busy=%b%b wait=%b%b%b expected 00 000", init_busy1, init_busy2, a1.waitrequest, b1.waitrequest, a2.waitrequest);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < DEPTH; i++) begin
      issue_read(0, AW'(i), 32'h0, 0);
    end
    issue_read(2, 4'd15, 32'h0, 0);
  endtask

  task automatic test_byte_enable();
    issue_write(0, 4'd5, 32'hAABBCCDD, 4'b1111);
    issue_write(0, 4'd5, 32'h11223344, 4'b0101);
    issue_read(1, 4'd5, 32'hAA22CC44, 0);
  endtask

  task automatic test_collision();
    drive(0, 1'b1, 1'b0, 1'b1, 4'd7, 4'hF, 32'h1);
    drive(1, 1'b1, 1'b0, 1'b1, 4'd7, 4'hF, 32'h2);
    @(negedge clk);
    checks++;
    if (b1.waitrequest !== 1'b1 || a1.waitrequest !== 1'b0) begin
      errors++;
      $display("FAIL collision_stall got s1_wait=%b s2_wait=%b expected 0 1", a1.waitrequest, b1.waitrequest);
    end
    @(posedge clk);
    #1;
    drive(0, 1'b0, 1'b0, 1'b0, '0, 4'h0, '0);
    @(negedge clk);
    checks++;
    if (b1.waitrequest !== 1'b0) begin
      errors++;
      $display("FAIL collision_retry got s2_wait=%b expected 0", b1.waitrequest);
    end
    @(posedge clk);
    #1;
    drive(1, 1'b0, 1'b0, 1'b0, '0, 4'h0, '0);
    issue_read(0, 4'd7, 32'h2, 0);
    // Different addresses never stall
    drive(0, 1'b1, 1'b0, 1'b1, 4'd8, 4'hF, 32'h8);
    drive(1, 1'b1, 1'b0, 1'b1, 4'd9, 4'hF, 32'h9);
    @(negedge clk);
    checks++;
    if (a1.waitrequest !== 1'b0 || b1.waitrequest !== 1'b0) begin
      errors++;
      $display("FAIL diff_addr_nostall got wait=%b%b expected 00", a1.waitrequest, b1.waitrequest);
    end
    @(posedge clk);
    #1;
    drive(0, 1'b0, 1'b0, 1'b0, '0, 4'h0, '0);
    drive(1, 1'b0, 1'b0, 1'b0, '0, 4'h0, '0);
    issue_read(1, 4'd8, 32'h8, 0);
    issue_read(0, 4'd9, 32'h9, 0);
  endtask

  task automatic test_cross_port_rdw();
    issue_write(0, 4'd2, 32'hA, 4'hF);
    drive(0, 1'b1, 1'b0, 1'b1, 4'd2, 4'hF, 32'hB);
    drive(1, 1'b1, 1'b1, 1'b0, 4'd2, 4'hF, '0);
    @(negedge clk);
    checks++;
    if (a1.waitrequest !== 1'b0 || b1.waitrequest !== 1'b0) begin
      errors++;
      $display("FAIL rdw_nostall got wait=%b%b expected 00", a1.waitrequest, b1.waitrequest);
    end
    push_exp(1, 32'hA, cyc + 2);
    @(posedge clk);
    #1;
    drive(0, 1'b0, 1'b0, 1'b0, '0, 4'h0, '0);
    drive(1, 1'b0, 1'b0, 1'b0, '0, 4'h0, '0);
    issue_read(1, 4'd2, 32'hB, 0);
  endtask

  task automatic test_enable_stall();
    issue_write(2, 4'd3, 32'h55, 4'hF);
    issue_read(2, 4'd3, 32'h55, 3);
    clken = 1'b0;
    @(negedge clk);
    checks++;
    if (a2.waitrequest !== 1'b1) begin
      errors++;
      $display("FAIL stall_wait got %b expected 1", a2.waitrequest);
    end
    repeat (3) @(posedge clk);
    #1;
    clken = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    reset_req = 1'b1;
    @(negedge clk);
    checks++;
    if (a1.waitrequest !== 1'b1 || a2.waitrequest !== 1'b1) begin
      errors++;
      $display("FAIL reset_req_wait got %b%b expected 11", a1.waitrequest, a2.waitrequest);
    end
    @(posedge clk);
    #1;
    reset_req = 1'b0;
  endtask

  task automatic test_reset_mid_sweep();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      checks++;
      if (init_busy1 !== 1'b1 || a1.waitrequest !== 1'b1) begin
        errors++;
        $display("FAIL resweep_busy cycle=%0d got busy=%b wait=%b expected 1 1", i, init_busy1, a1.waitrequest);
      end
    end
    @(negedge clk);
    checks++;
    if (init_busy1 !== 1'b0) begin
      errors++;
      $display("FAIL resweep_done got busy=%b expected 0", init_busy1);
    end
    @(posedge clk);
    #1;
    issue_read(0, 4'd5, 32'h0, 0);
    issue_read(1, 4'd2, 32'h0, 0);
    issue_read(2, 4'd3, 32'h0, 0);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    reset_req = 1'b0;
    clken     = 1'b1;
    drive(0, 1'b0, 1'b0, 1'b0, '0, 4'h0, '0);
    drive(1, 1'b0, 1'b0, 1'b0, '0, 4'h0, '0);
    drive(2, 1'b0, 1'b0, 1'b0, '0, 4'h0, '0);
    b2.chipselect = 1'b0; b2.read = 1'b0; b2.write = 1'b0;
    b2.address = '0; b2.byteenable = '0; b2.writedata = '0;

    test_reset();
    test_clear_sweep();
    test_byte_enable();
    test_collision();
    test_cross_port_rdw();
    test_enable_stall();
    test_reset_mid_sweep();

    repeat (8) @(negedge clk);
    checks++;
    if (q0.size() + q1.size() + q2.size() != 0) begin
      errors++;
      $display("FAIL pending_reads got %0d/%0d/%0d outstanding expected 0/0/0", q0.size(), q1.size(), q2.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
